stream_mux_arb: RTL and testbench
=================================

STREAM_MUX_ARB -- requirements
Module: stream_mux_arb

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter W, default 8, meaning the data width per channel.
REQ-003 The block SHALL have parameter MODE, default 0, meaning 0 = select-driven and 1 = round-robin arbitration.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port in_data, input, N*W bits: channel i occupies bits [i*W+W-1 : i*W].
REQ-007 The block SHALL have port in_valid, input, N bits: per-channel valid.
REQ-008 The block SHALL have port in_ready, output, N bits: per-channel ready (combinational).
REQ-009 The block SHALL have port sel, input, S = max(1, clog2(N)) bits: the channel select, used only when MODE = 0.
REQ-010 The block SHALL have port out_data, output, W bits: the registered output data.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the registered output valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-013 The block SHALL have port grant_idx, output, S bits: the registered index of the channel whose data is in out_data.

Function
REQ-014 The output slot SHALL be free in a cycle when out_valid = 0 or out_ready = 1 (slot_free).
REQ-015 When MODE = 0, the candidate channel SHALL be sel; if sel >= N, there SHALL be no candidate.
REQ-016 When MODE = 1, the candidate SHALL be the first channel with in_valid = 1, searching from (rr_ptr+1) mod N upward with wrap-around.
REQ-017 in_ready[i] SHALL be 1 only when slot_free = 1 and i is the candidate; all other bits SHALL be 0.
REQ-018 In MODE = 0, in_ready[sel] SHALL be 1 when slot_free = 1, regardless of in_valid[sel].
REQ-019 A transfer SHALL occur on a channel when in_valid[i] = 1 and in_ready[i] = 1 at a rising edge.
REQ-020 On a transfer, the next cycle SHALL show out_data = that channel's data, out_valid = 1, and grant_idx = i (latency 1 cycle).
REQ-021 On a transfer in MODE = 1, the internal pointer rr_ptr SHALL be set to i.
REQ-022 If slot_free = 1 and no transfer occurs, out_valid SHALL go to 0 on the next edge, and out_data and grant_idx SHALL hold their values.
REQ-023 While out_valid = 1 and out_ready = 0, out_data, grant_idx and out_valid SHALL remain stable, and all in_ready bits SHALL be 0.
REQ-024 A downstream accept and a new transfer in the same cycle SHALL both take effect, giving a sustained throughput of 1 word per cycle.
REQ-025 In MODE = 1, when all N channels are valid continuously with out_ready = 1, grants SHALL rotate 0, 1, ..., N-1, 0, ... with no channel starved.
REQ-026 In MODE = 1, a channel dropping in_valid before it is granted SHALL simply be skipped; no word SHALL be lost or duplicated.
REQ-027 In MODE = 0, a change of sel while out_valid = 1 and stalled SHALL NOT alter the held output word.

Reset
REQ-028 When rst_n = 0 at a rising edge, out_valid SHALL become 0, out_data SHALL become 0, grant_idx SHALL become 0, and rr_ptr SHALL become N-1 (so channel 0 has first priority).
REQ-029 While rst_n = 0, in_ready SHALL be all zeros.
REQ-030 A word held in the output stage when reset is asserted SHALL be discarded.
REQ-031 After rst_n returns to 1, normal operation SHALL begin on the first edge.

Verification
REQ-032 The bench SHALL run this MODE = 0, N = 4, W = 8 scenario: in_data = {8'h44, 8'h33, 8'h22, 8'h11}, all valid, out_ready = 1, sel stepping 0, 1, 2, 3 one per cycle -> out_data = 11, 22, 33, 44, one cycle after each sel, with grant_idx = 0..3.
REQ-033 The bench SHALL run this MODE = 0 stall scenario: sel = 2, out_ready = 0 for 3 cycles while sel changes to 1 -> out_data stays 8'h33 and in_ready = 0000 during the stall; when out_ready = 1, the next word comes from channel 1.
REQ-034 The bench SHALL run this MODE = 1 fairness scenario: all 4 channels valid, out_ready = 1 for 8 cycles after reset -> grant_idx sequence is 0, 1, 2, 3, 0, 1, 2, 3 with out_valid = 1 continuously.
REQ-035 The bench SHALL run this MODE = 1 sparse scenario: only channels 1 and 3 valid -> grants alternate 1, 3, 1, 3, and in_ready[0] and in_ready[2] stay 0.
REQ-036 The bench SHALL run this reset scenario: assert rst_n = 0 for 1 cycle while out_valid = 1 and stalled -> next cycle out_valid = 0, out_data = 0, grant_idx = 0; the first MODE = 1 grant after reset goes to channel 0.
REQ-037 The bench SHALL run this idle scenario: in_valid = 0000 with out_ready = 1 -> out_valid falls to 0 one cycle after the last transfer, and out_data holds its last value.

Source files
------------

// File: rtl/stream_mux_arb.sv
// N-to-1 stream multiplexer. The channel comes from sel (MODE 0) or from a round-robin arbiter (MODE 1).
// There is one registered output stage, which can accept a new word in the same cycle that downstream takes the current one.
module stream_mux_arb #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  localparam int S   = (N < 2) ? 1 : $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [S-1:0]   sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [S-1:0]   grant_idx
);

  logic           slot_free;
  logic [S-1:0]   cand;
  logic           cand_ok;
  logic [W-1:0]   cand_data;
  logic [N-1:0]   ready;
  logic           transfer;
  logic [S-1:0]   rr_ptr;

  assign slot_free = !out_valid || out_ready;

  // In round-robin mode the search starts one past the last grant, so the winner of the last grant is searched last.
  always_comb begin
    int idx;
    idx     = 0;
    cand    = '0;
    cand_ok = 1'b0;
    if (MODE == 0) begin
      cand    = sel;
      cand_ok = (32'(sel) < N);
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(rr_ptr) + k) % N;
        if (!cand_ok && in_valid[idx[S-1:0]]) begin
          cand_ok = 1'b1;
          cand    = idx[S-1:0];
        end
      end
    end
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < N; i++) begin
      if (cand == S'(i)) cand_data = in_data[i*W +: W];
    end
  end

  always_comb begin
    ready = '0;
    if (rst_n && slot_free && cand_ok) ready[cand] = 1'b1;
  end

  assign in_ready = ready;
  assign transfer = |(in_valid & ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_idx <= '0;
      rr_ptr    <= S'(N - 1);
    end else if (slot_free) begin
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= cand_data;
        grant_idx <= cand;
        if (MODE == 1) rr_ptr <= cand;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Testbench for stream_mux_arb. It runs a MODE 0 and a MODE 1 instance side by side on the same inputs.
// Each instance is checked against a behavioural model of the output slot and the round-robin priority.
module tb_stream_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  rdy0, rdy1;
  logic [7:0]  od0, od1;
  logic        ov0, ov1;
  logic [1:0]  gi0, gi1;

  int vectors = 0;
  int errors  = 0;

  // model state, index 0 = MODE 0 instance, 1 = MODE 1 instance
  bit         m_ov[2];
  logic [7:0] m_od[2];
  logic [1:0] m_og[2];
  int         m_rr[2];

  always #5 clk = ~clk;

  stream_mux_arb #(.N(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .sel(sel), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .grant_idx(gi0));

  stream_mux_arb #(.N(4), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .sel(sel), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .grant_idx(gi1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_ready(input int m);
    if (!rst_n || (m_ov[m] && !out_ready)) return 4'b0000;
    if (m == 0) return 4'b0001 << sel;
    for (int off = 1; off <= 4; off++) begin
      int c;
      c = (m_rr[m] + off) % 4;
      if (in_valid[c]) return 4'b0001 << c;
    end
    return 4'b0000;
  endfunction

  task automatic model_edge(input int m, input logic [3:0] r);
    logic [3:0] hit;
    hit = in_valid & r;
    if (!rst_n) begin
      m_ov[m] = 1'b0; m_od[m] = 8'h00; m_og[m] = 2'd0; m_rr[m] = 3;
    end else if (!m_ov[m] || out_ready) begin
      m_ov[m] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (hit[c]) begin
          m_ov[m] = 1'b1;
          m_od[m] = 8'((in_data >> (8 * c)) & 32'hff);
          m_og[m] = 2'(c);
          m_rr[m] = c;
        end
      end
    end
  endtask

  // one clock: check in_ready with the inputs already applied, clock it, then check the registered outputs
  task automatic tick();
    logic [3:0] r0, r1;
    #1;
    r0 = exp_ready(0);
    r1 = exp_ready(1);
    chk("in_ready_m0", 32'(rdy0), 32'(r0));
    chk("in_ready_m1", 32'(rdy1), 32'(r1));
    @(posedge clk);
    model_edge(0, r0);
    model_edge(1, r1);
    #1;
    chk("out_valid_m0", 32'(ov0), 32'(m_ov[0]));
    chk("out_data_m0",  32'(od0), 32'(m_od[0]));
    chk("grant_m0",     32'(gi0), 32'(m_og[0]));
    chk("out_valid_m1", 32'(ov1), 32'(m_ov[1]));
    chk("out_data_m1",  32'(od1), 32'(m_od[1]));
    chk("grant_m1",     32'(gi1), 32'(m_og[1]));
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; sel = '0; out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_ov[m] = 1'b0; m_od[m] = '0; m_og[m] = '0; m_rr[m] = 3;
    end
    @(posedge clk); #1;
    tick();
    tick();
    chk("reset_valid", 32'(ov0), 32'd0);
    chk("reset_data",  32'(od1), 32'd0);

    // select-driven sweep
    rst_n = 1'b1; in_data = 32'h44332211; in_valid = 4'hf; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      tick();
      chk("sweep_data",  32'(od0), 32'h11 * (k + 1));
      chk("sweep_grant", 32'(gi0), 32'(k));
      chk("sweep_valid", 32'(ov0), 32'd1);
    end

    // stall while sel moves: the held word must not change
    sel = 2'd2;
    tick();
    chk("stall_load", 32'(od0), 32'h33);
    out_ready = 1'b0; sel = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 32'(rdy0), 32'd0);
      tick();
      chk("stall_hold", 32'(od0), 32'h33);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_next_data",  32'(od0), 32'h22);
    chk("stall_next_grant", 32'(gi0), 32'd1);

    // reset while stalled with a word held
    out_ready = 1'b0; rst_n = 1'b0;
    tick();
    chk("rst_hold_valid", 32'(ov0), 32'd0);
    chk("rst_hold_data",  32'(od0), 32'd0);
    chk("rst_hold_grant", 32'(gi0), 32'd0);
    chk("rst_hold_v1",    32'(ov1), 32'd0);

    // round-robin fairness from reset
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'hf;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_grant", 32'(gi1), 32'(k % 4));
      chk("rr_valid", 32'(ov1), 32'd1);
    end

    // sparse requests: channels 1 and 3 only
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sparse_ready02", 32'(rdy1 & 4'b0101), 32'd0);
      tick();
      chk("sparse_grant", 32'(gi1), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // idle: output slot drains and data holds
    in_valid = 4'b0000;
    tick();
    chk("idle_valid", 32'(ov1), 32'd0);
    chk("idle_data",  32'(od1), 32'h44);
    tick();
    chk("idle_data2", 32'(od1), 32'h44);

    // random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
